// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div with HI/LO ownership.
// Results are computed at issue and committed to HI/LO after the busy window.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               busy_d;
    logic [31:0]        hi_d, lo_d;
    logic [63:0]        pend, pend_d;
    logic               pend_wr, pend_wr_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, q_s, r_s;
    logic [31:0] rt_div, q_u, r_u;

    // Sign-extended 64x64 keeps the low 64 bits equal to the signed 32x32 product
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide via magnitudes; a zero divisor is replaced so no X appears
    assign a_mag  = rs[31] ? (32'd0 - rs) : rs;
    assign b_mag  = rt[31] ? (32'd0 - rt) : rt;
    assign b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_div;
    assign r_mag  = a_mag % b_div;
    assign q_s    = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s    = rs[31] ? (32'd0 - r_mag) : r_mag;

    assign rt_div = (rt == 32'd0) ? 32'd1 : rt;
    assign q_u    = rs / rt_div;
    assign r_u    = rs % rt_div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            busy    <= busy_d;
            hi      <= hi_d;
            lo      <= lo_d;
            pend    <= pend_d;
            pend_wr <= pend_wr_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        busy_d    = busy;
        hi_d      = hi;
        lo_d      = lo;
        pend_d    = pend;
        pend_wr_d = pend_wr;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            pend_d    = (op == OP_MULT) ? prod_s : prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = RUN;
                            busy_d    = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_d    = (op == OP_DIV) ? {r_s, q_s} : {r_u, q_u};
                            pend_wr_d = (rt != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = RUN;
                            busy_d    = 1'b1;
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt - CNT_W'(1);
                // Last busy cycle: commit result (suppressed for divide by zero)
                if (cnt == CNT_W'(1)) begin
                    if (pend_wr) begin
                        hi_d = pend[63:32];
                        lo_d = pend[31:0];
                    end
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expected HI/LO and busy length,
// a monitor checks them each time busy falls.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles, compare against scoreboard when busy falls
    initial begin
        int   busy_cnt;
        logic busy_prev;
        exp_t e;
        busy_cnt  = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_cnt  = 0;
                busy_prev = 1'b0;
            end else begin
                if (busy === 1'b1) begin
                    busy_cnt++;
                end else if (busy_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: busy fell with empty scoreboard hi=%h lo=%h", hi, lo);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_hi"}, hi, e.hi);
                        chk({e.name, "_lo"}, lo, e.lo);
                        chk({e.name, "_cycles"}, 32'(busy_cnt), 32'(e.cyc));
                    end
                    busy_cnt = 0;
                end
                busy_prev = busy;
            end
        end
    end

    // Issue one op at the current negedge and queue its expected outcome
    task automatic go(input string name, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                      input int cyc);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.cyc = cyc; e.name = name;
        sb.push_back(e);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: busy still %b after 40 cycles, required 0", name, busy);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
        @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        go("mult", 3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        wait_idle("mult");
        @(negedge clk);
        go("multu", 3'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5);
        wait_idle("multu");
        go("div_neg", 3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        wait_idle("div_neg");
        go("div_negdivisor", 3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
        wait_idle("div_negdivisor");
        go("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
        wait_idle("div_ovf");

        // mthi/mtlo: old value visible in the issue cycle, new value after the edge
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs = 32'h11111111;
        #1 chk("mthi_same_cycle", hi, 32'h00000000);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        chk("mthi_after", hi, 32'h11111111);
        chk("mthi_no_busy", 32'(busy), 32'd0);
        start = 1'b1; op = 3'd6; rs = 32'h22222222;
        #1 chk("mtlo_same_cycle", lo, 32'h80000000);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        chk("mtlo_after", lo, 32'h22222222);

        go("divu_zero", 3'd4, 32'h12345678, 32'h00000000, 32'h11111111, 32'h22222222, 10);
        wait_idle("divu_zero");

        // start during RUN must be ignored, including mtlo
        @(negedge clk);
        go("mult_ignored", 3'd1, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A, 5);
        start = 1'b1; op = 3'd6; rs = 32'hDEADBEEF;
        @(negedge clk);
        op = 3'd2; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        wait_idle("mult_ignored");

        // Back-to-back: next op issued in the cycle busy falls
        @(negedge clk);
        go("b2b_divu", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        wait_idle("b2b_divu");
        go("b2b_multu", 3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5);
        wait_idle("b2b_multu");

        // Async reset mid-operation aborts with no HI/LO update
        @(negedge clk);
        start = 1'b1; op = 3'd1; rs = 32'h00000003; rt = 32'h00000005;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_hi", hi, 32'd0);
        chk("async_reset_lo", lo, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_hi", hi, 32'd0);
        chk("post_reset_lo", lo, 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
